// File: rtl/bs_pkg.sv
// Shared definitions for the serial ALU operand sequencer:
// ALU op codes and the sequencer state encoding.
package bs_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_SLLI = 3'b101;
    localparam logic [2:0] OP_SRLI = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_CAPT = 2'b10,
        ST_DONE = 2'b11
    } seq_state_e;

endpackage

// File: rtl/alu_serial_seq.sv
// Operand sequencer around a 1-bit serial ALU: streams operands LSB-first
// and reassembles the result. ALU_SEQ_SHIFT_EN enables SLLI/SRLI remapping.
module alu_serial_seq
    import bs_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_op,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic [$clog2(WIDTH)-1:0] in_shamt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic                     alu_rs1,
    output logic                     alu_rs2,
    output logic [2:0]               alu_op,
    output logic                     alu_en,
    output logic                     alu_start,
    input  logic                     alu_result
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [SW-1:0] LAST_I = SW'(WIDTH - 1);

    seq_state_e       state_q, state_d;
    logic [SW-1:0]    i_q, i_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             cap_en_q, cap_en_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             alu_en_q, alu_en_d;
    logic             alu_start_q, alu_start_d;
    logic             alu_rs1_q, alu_rs1_d;
    logic             alu_rs2_q, alu_rs2_d;
    logic [SW-1:0]    idx;
    logic             src_ok;

`ifdef ALU_SEQ_SHIFT_EN
    localparam int SW1 = SW + 1;
    localparam logic [SW:0] W_LIM = SW1'(WIDTH);
    logic [SW-1:0] shamt_q, shamt_d;
    logic [SW:0]   sft;
`else
    logic unused_shamt;
    assign unused_shamt = ^in_shamt;
`endif

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
`ifdef ALU_SEQ_SHIFT_EN
        shamt_d  = shamt_q;
`endif
        cap_en_d = alu_en_q;
        res_d    = cap_en_q ? {alu_result, res_q[WIDTH-1:1]} : res_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    op_d    = in_op;
`ifdef ALU_SEQ_SHIFT_EN
                    shamt_d = in_shamt;
`endif
                    i_d     = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_q == LAST_I) begin
                    state_d = ST_CAPT;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            ST_CAPT: state_d = ST_DONE;
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // ALU-facing bits are computed from next-state values so they register
        idx    = i_d;
        src_ok = 1'b1;
`ifdef ALU_SEQ_SHIFT_EN
        sft = '0;
        if (op_d == OP_SLLI) begin
            src_ok = (i_d >= shamt_d);
            idx    = i_d - shamt_d;
        end else if (op_d == OP_SRLI) begin
            sft    = {1'b0, i_d} + {1'b0, shamt_d};
            src_ok = (sft < W_LIM);
            idx    = sft[SW-1:0];
        end
`endif
        alu_en_d    = (state_d == ST_RUN);
        alu_start_d = alu_en_d && (state_q == ST_IDLE);
        alu_rs2_d   = alu_en_d && b_d[i_d];
        alu_rs1_d   = alu_en_d && src_ok && a_d[idx];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            i_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
`ifdef ALU_SEQ_SHIFT_EN
            shamt_q     <= '0;
`endif
            cap_en_q    <= 1'b0;
            res_q       <= '0;
            alu_en_q    <= 1'b0;
            alu_start_q <= 1'b0;
            alu_rs1_q   <= 1'b0;
            alu_rs2_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
`ifdef ALU_SEQ_SHIFT_EN
            shamt_q     <= shamt_d;
`endif
            cap_en_q    <= cap_en_d;
            res_q       <= res_d;
            alu_en_q    <= alu_en_d;
            alu_start_q <= alu_start_d;
            alu_rs1_q   <= alu_rs1_d;
            alu_rs2_q   <= alu_rs2_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign out_result = res_q;
    assign alu_op     = op_q;
    assign alu_en     = alu_en_q;
    assign alu_start  = alu_start_q;
    assign alu_rs1    = alu_rs1_q;
    assign alu_rs2    = alu_rs2_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Self-checking bench for alu_serial_seq with a behavioural serial ALU
// and a result model; follows ALU_SEQ_SHIFT_EN for shift expectations.
module tb_alu_serial_seq;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [2:0]   in_shamt;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         alu_rs1;
    logic         alu_rs2;
    logic [2:0]   alu_op;
    logic         alu_en;
    logic         alu_start;
    logic         alu_result;

    alu_serial_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_shamt  (in_shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .alu_rs1   (alu_rs1),
        .alu_rs2   (alu_rs2),
        .alu_op    (alu_op),
        .alu_en    (alu_en),
        .alu_start (alu_start),
        .alu_result(alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timeout at cycle %0d", nm, cyc);
    endtask

    // Serial ALU: registered result bit, carry cleared while disabled
    logic alu_carry;
    always @(posedge clk) begin
        logic cin;
        logic rb;
        if (alu_en !== 1'b1) begin
            alu_carry  <= 1'b0;
            alu_result <= 1'b0;
        end else begin
            cin = alu_carry | (alu_start && alu_op == 3'b001);
            rb  = (alu_op == 3'b001) ? ~alu_rs2 : alu_rs2;
            case (alu_op)
                3'b000, 3'b001: begin
                    alu_result <= alu_rs1 ^ rb ^ cin;
                    alu_carry  <= (alu_rs1 & rb) | (alu_rs1 & cin) | (rb & cin);
                end
                3'b010:         alu_result <= alu_rs1 ^ alu_rs2;
                3'b011:         alu_result <= alu_rs1 & alu_rs2;
                3'b100:         alu_result <= alu_rs1 | alu_rs2;
                3'b101, 3'b110: alu_result <= alu_rs1;
                default:        alu_result <= 1'b0;
            endcase
        end
    end

    function automatic logic [W-1:0] model(input logic [2:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [2:0] sh);
        case (op)
            3'b000: return a + b;
            3'b001: return a - b;
            3'b010: return a ^ b;
            3'b011: return a & b;
            3'b100: return a | b;
`ifdef ALU_SEQ_SHIFT_EN
            3'b101: return a << sh;
            3'b110: return a >> sh;
`else
            3'b101: return a;
            3'b110: return a;
`endif
            default: return '0;
        endcase
    endfunction

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] lit;
        int           acc;
    } exp_t;

    exp_t         q[$];
    logic [W-1:0] cur_lit;
    int           en_cnt;
    int           st_cnt;

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        logic busy;
        logic vld;
        if (!rst_n) begin
            q.delete();
        end else begin
            busy = (q.size() > 0);
            vld  = busy && (cyc >= q[0].acc + W + 1);
            chk("in_ready", in_ready, !busy);
            chk("out_valid", out_valid, vld);
            if (vld) chk("result_model", out_result, q[0].res);
            if (busy && !vld) begin
                en_cnt += alu_en ? 1 : 0;
                st_cnt += alu_start ? 1 : 0;
            end
            if (vld && out_ready) begin
                chk("result_literal", out_result, q[0].lit);
                chk("alu_en_cycles", en_cnt, W);
                chk("alu_start_pulses", st_cnt, 1);
                void'(q.pop_front());
            end
            if (in_valid && in_ready) begin
                q.push_back('{model(in_op, in_a, in_b, in_shamt), cur_lit, cyc + 1});
                en_cnt = 0;
                st_cnt = 0;
            end
        end
    end

    task automatic chk_reset();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_alu_en", alu_en, 0);
        chk("rst_alu_start", alu_start, 0);
        chk("rst_alu_rs1", alu_rs1, 0);
        chk("rst_alu_rs2", alu_rs2, 0);
        chk("rst_alu_op", alu_op, 0);
    endtask

    task automatic wait_accept(output int acc);
        acc = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = cyc + 1;
                break;
            end
        end
        if (acc < 0) timeout("accept");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out();
        bit seen = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1;
                break;
            end
        end
        if (!seen) timeout("out_valid");
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [2:0] sh,
                         input logic [W-1:0] lit);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_shamt = sh;
        cur_lit  = lit;
    endtask

    task automatic do_op(input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [2:0] sh,
                         input logic [W-1:0] lit);
        int acc;
        drive(op, a, b, sh, lit);
        wait_accept(acc);
        in_valid = 1'b0;
        wait_out();
    endtask

    logic [W-1:0] shl_lit;
    logic [W-1:0] shr_lit;

    initial begin
        int a1;
        int a2;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        in_shamt  = '0;
        out_ready = 1'b1;
        cur_lit   = '0;
        en_cnt    = 0;
        st_cnt    = 0;
`ifdef ALU_SEQ_SHIFT_EN
        shl_lit = 8'h08;
        shr_lit = 8'h10;
`else
        shl_lit = 8'h81;
        shr_lit = 8'h81;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_op(3'b000, 8'h5A, 8'h3C, 3'd0, 8'h96);
        do_op(3'b001, 8'h10, 8'h01, 3'd0, 8'h0F);
        do_op(3'b001, 8'h00, 8'h01, 3'd0, 8'hFF);
        do_op(3'b011, 8'hCC, 8'hAA, 3'd0, 8'h88);
        do_op(3'b100, 8'hC0, 8'h03, 3'd0, 8'hC3);
        do_op(3'b101, 8'h81, 8'h5A, 3'd3, shl_lit);
        do_op(3'b110, 8'h81, 8'h5A, 3'd3, shr_lit);
        do_op(3'b111, 8'h12, 8'h34, 3'd0, 8'h00);

        // Back-to-back with out_ready held high
        drive(3'b000, 8'hFF, 8'h01, 3'd0, 8'h00);
        wait_accept(a1);
        drive(3'b000, 8'h01, 8'h01, 3'd0, 8'h02);
        wait_accept(a2);
        in_valid = 1'b0;
        chk("b2b_period", a2 - a1, W + 3);
        wait_out();

        // Backpressure with a competing request
        out_ready = 1'b0;
        drive(3'b100, 8'h0F, 8'hF0, 3'd0, 8'hFF);
        wait_accept(a1);
        drive(3'b000, 8'h11, 8'h22, 3'd0, 8'h33);
        wait_out();
        repeat (5) @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset while bit 3 is on the ALU
        drive(3'b000, 8'h5A, 8'h3C, 3'd0, 8'h96);
        wait_accept(a1);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_op(3'b010, 8'hF0, 8'hFF, 3'd0, 8'h0F);

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
